// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the UART0 receive path: register
//             offsets within the UART0 window, RXSTAT/RXDATA bit positions,
//             the receiver state encoding and a count-saturation helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Byte offsets from the UART0 base; RX words follow TX data/status.
  localparam logic [3:0] RXDATA_OFS = 4'h8;
  localparam logic [3:0] RXSTAT_OFS = 4'hC;

  // RXSTAT bit positions
  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_FERR    = 2;
  localparam int ST_OVR     = 3;
  localparam int ST_CNT_LSB = 4;

  // RXDATA valid flag position
  localparam int RXD_VALID  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

  // RXSTAT only has a 4-bit count field; a 16-deep FIFO reports 15 when full.
  function automatic logic [3:0] sat_count(input int unsigned n);
    return (n > 15) ? 4'hF : n[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart0_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart0_rx_if
//  Purpose  : CPU-side bus of the UART0 receiver (RX window of 8 bytes).
//  Signals  : cs   - window select
//             rd   - one-cycle read strobe, qualified by cs
//             adr  - word select, 0 = RXDATA, 1 = RXSTAT
//             dout - registered read data (valid the cycle after the strobe)
//             irq  - level interrupt, high while the FIFO holds data
//  Revision : 1.0  initial release
// ============================================================================
interface uart0_rx_if;
  logic        cs;
  logic        rd;
  logic        adr;
  logic [31:0] dout;
  logic        irq;

  modport master (output cs, rd, adr, input dout, irq);
  modport slave  (input cs, rd, adr, output dout, irq);
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Small register-array FIFO for received bytes. A push while full
//             is accepted only if a pop happens in the same cycle; otherwise
//             it is ignored and the contents are left untouched.
//  Ports    : CLK, RESET (async, active high)
//             i_push/i_wdata - write side
//             i_pop/o_rdata  - read side, o_rdata is the current head
//             o_full, o_empty, o_count - occupancy
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  wire logic                     CLK,
  input  wire logic                     RESET,
  input  wire logic                     i_push,
  input  wire logic [7:0]               i_wdata,
  input  wire logic                     i_pop,
  output logic      [7:0]               o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A slot frees up at this edge if the head is being popped.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart0_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart0_rx
//  Purpose  : Memory-mapped 8N1 UART receiver with byte FIFO, read-to-pop
//             data register, read-to-clear status register and level irq.
//  Ports    : CLK   - system clock
//             RESET - asynchronous active-high reset
//             RX    - serial input, idle high, asynchronous to CLK
//             bus   - uart0_rx_if slave (cs, rd, adr, dout, irq)
//  Revision : 1.0  initial release
// ============================================================================
module uart0_rx
  import uart_pkg::*;
#(
  parameter int F_CLK = 12000000,
  parameter int BAUD  = 115200,
  parameter int DEPTH = 4
) (
  input  wire logic  CLK,
  input  wire logic  RESET,
  input  wire logic  RX,
  uart0_rx_if.slave  bus
);
  localparam int c_div = F_CLK / BAUD;
  localparam int CW    = $clog2(c_div);
  localparam int AW    = $clog2(DEPTH);
  // Counter expires at 0, so loading N-1 gives a period of N cycles.
  localparam logic [CW-1:0] c_half = CW'(c_div / 2 - 1);
  localparam logic [CW-1:0] c_full = CW'(c_div - 1);

  logic           r_rx_meta;
  logic           r_rx_sync;
  logic           r_rx_prev;
  rx_state_t      r_state;
  logic [CW-1:0]  r_baud_cnt;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_ferr;
  logic           r_ovr;
  logic [31:0]    r_dout;

  logic           w_fall;
  logic           w_tick;
  logic           w_stop_tick;
  logic           w_push;
  logic           w_set_ferr;
  logic           w_set_ovr;
  logic           w_rd_data;
  logic           w_rd_stat;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [AW:0]    w_count;
  logic [7:0]     w_head;

  // Two-flop synchroniser plus one extra stage for edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall      = r_rx_prev && !r_rx_sync;
  assign w_tick      = (r_baud_cnt == '0);
  assign w_stop_tick = (r_state == S_STOP) && w_tick;
  assign w_push      = w_stop_tick && r_rx_sync;
  assign w_set_ferr  = w_stop_tick && !r_rx_sync;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_baud_cnt <= c_half;
          end
        end
        S_START: begin
          if (w_tick) begin
            // Line back high at mid start bit: a glitch, drop silently.
            if (!r_rx_sync) begin
              r_state    <= S_DATA;
              r_baud_cnt <= c_full;
              r_bit_cnt  <= '0;
            end else begin
              r_state    <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift    <= {r_rx_sync, r_shift[7:1]};
            r_baud_cnt <= c_full;
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
            else                   r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end
        S_STOP: begin
          // Returning at mid stop bit leaves half a bit to catch the next start.
          if (w_tick) r_state    <= S_IDLE;
          else        r_baud_cnt <= r_baud_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_rd_data = bus.cs && bus.rd && !bus.adr;
  assign w_rd_stat = bus.cs && bus.rd &&  bus.adr;
  assign w_pop     = w_rd_data && !w_empty;
  // A simultaneous pop makes room, so that push is not an overrun.
  assign w_set_ovr = w_push && w_full && !w_pop;

  // Sticky flags: a set in the same cycle as the clearing read wins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ferr <= w_set_ferr || (r_ferr && !w_rd_stat);
      r_ovr  <= w_set_ovr  || (r_ovr  && !w_rd_stat);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dout <= '0;
    end else if (w_rd_data) begin
      r_dout <= w_empty ? 32'd0 : {23'd0, 1'b1, w_head};
    end else if (w_rd_stat) begin
      r_dout <= {24'd0, sat_count(32'(w_count)), r_ovr, r_ferr, w_full, !w_empty};
    end
  end

  assign bus.dout = r_dout;
  assign bus.irq  = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart0_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart0_rx
//  Purpose  : Self-checking bench for uart0_rx. Frames are driven on RX and
//             the register interface is compared against a queue-based model
//             of the FIFO and sticky flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart0_rx;
  localparam int F_CLK = 1843200;
  localparam int BAUD  = 115200;
  localparam int DEPTH = 4;
  localparam int DIV   = F_CLK / BAUD;          // 16
  localparam int STOP_SAMPLE = 2 + DIV/2 + 9*DIV; // cycles from start edge

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart0_rx_if bus();

  uart0_rx #(
    .F_CLK (F_CLK),
    .BAUD  (BAUD),
    .DEPTH (DEPTH)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .RX    (rx),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: received bytes plus sticky flags.
  logic [7:0] m_q[$];
  bit         m_ferr = 1'b0;
  bit         m_ovr  = 1'b0;

  function automatic void model_frame(input logic [7:0] b, input logic stop);
    if (!stop)                  m_ferr = 1'b1;
    else if (m_q.size() < DEPTH) m_q.push_back(b);
    else                        m_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] model_stat();
    int unsigned n;
    logic [31:0] s;
    n = m_q.size();
    s = {24'd0, ((n > 15) ? 4'hF : 4'(n)), m_ovr, m_ferr, (n == DEPTH), (n != 0)};
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] model_data();
    if (m_q.size() == 0) return 32'd0;
    return {23'd0, 1'b1, m_q.pop_front()};
  endfunction

  // All stimulus tasks start and end on a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    bus.cs  = 1'b1;
    bus.rd  = 1'b1;
    bus.adr = a;
    @(negedge clk);
    bus.cs  = 1'b0;
    bus.rd  = 1'b0;
    d = bus.dout;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.dout !== 32'd0 || bus.irq !== 1'b0)
      $display("FAIL reset_outputs: dout=%h irq=%b, expected dout=0 irq=0", bus.dout, bus.irq);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_stat: got %h expected %h", d, 32'h0);
    else n_pass++;
    bus_read(1'b0, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_data: got %h expected %h", d, 32'h0);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [31:0] d, e;
    logic        irq_before, irq_after;
    fork
      send_frame(8'h61, 1'b1);
      begin
        repeat (STOP_SAMPLE) @(negedge clk);
        irq_before = bus.irq;
        @(negedge clk);
        irq_after = bus.irq;
      end
    join
    model_frame(8'h61, 1'b1);
    n_checks++;
    if (irq_before !== 1'b0 || irq_after !== 1'b1)
      $display("FAIL irq_rise: before=%b after=%b expected 0 then 1", irq_before, irq_after);
    else n_pass++;
    // Unselected strobe must not pop or change dout (last read returned 0).
    bus.cs = 1'b0; bus.rd = 1'b1; bus.adr = 1'b0;
    @(negedge clk);
    bus.rd = 1'b0;
    n_checks++;
    if (bus.dout !== 32'd0) $display("FAIL nosel_read: dout=%h expected %h", bus.dout, 32'd0);
    else n_pass++;
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL single_stat: got %h expected %h", d, e);
    else n_pass++;
    bus_read(1'b0, d); e = model_data();
    n_checks++;
    if (d !== e) $display("FAIL single_data: got %h expected %h", d, e);
    else n_pass++;
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL single_stat_after: got %h expected %h", d, e);
    else n_pass++;
  endtask

  task automatic test_framing_error();
    logic [31:0] d, e;
    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    repeat (DIV) @(negedge clk);
    n_checks++;
    if (bus.irq !== 1'b0) $display("FAIL ferr_irq: irq=%b expected 0", bus.irq);
    else n_pass++;
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL ferr_stat: got %h expected %h", d, e);
    else n_pass++;
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL ferr_cleared: got %h expected %h", d, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back_overflow();
    logic [31:0] d, e;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      model_frame(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL ovf_stat: got %h expected %h", d, e);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      bus_read(1'b0, d); e = model_data();
      n_checks++;
      if (d !== e) $display("FAIL ovf_data%0d: got %h expected %h", i, d, e);
      else n_pass++;
    end
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL ovf_stat_after: got %h expected %h", d, e);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3*DIV) @(negedge clk);
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e || bus.irq !== 1'b0)
      $display("FAIL glitch_stat: got %h irq=%b expected %h irq=0", d, bus.irq, e);
    else n_pass++;
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(1'b0, d); e = model_data();
    n_checks++;
    if (d !== e) $display("FAIL glitch_next: got %h expected %h", d, e);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d, e;
    logic [7:0]  b;
    send_frame(8'h77, 1'b1);
    model_frame(8'h77, 1'b1);
    b = 8'hA5;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.irq !== 1'b0 || bus.dout !== 32'd0)
      $display("FAIL midreset_outputs: irq=%b dout=%h expected irq=0 dout=0", bus.irq, bus.dout);
    else n_pass++;
    rx = 1'b1;
    m_q.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2*DIV) @(negedge clk);
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL midreset_stat: got %h expected %h", d, e);
    else n_pass++;
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(1'b0, d); e = model_data();
    n_checks++;
    if (d !== e) $display("FAIL midreset_next: got %h expected %h", d, e);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d, e, dr, er;
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1);
      model_frame(8'h11 + 8'(i), 1'b1);
    end
    // Read strobe lands exactly on the stop-bit sample edge of the next frame.
    fork
      send_frame(8'h15, 1'b1);
      begin
        repeat (STOP_SAMPLE) @(negedge clk);
        bus_read(1'b0, dr);
      end
    join
    er = model_data();
    model_frame(8'h15, 1'b1);
    n_checks++;
    if (dr !== er) $display("FAIL pushpop_data: got %h expected %h", dr, er);
    else n_pass++;
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL pushpop_stat: got %h expected %h", d, e);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(1'b0, d); e = model_data();
      n_checks++;
      if (d !== e) $display("FAIL pushpop_drain%0d: got %h expected %h", i, d, e);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic [7:0]  b;
    logic        stop;
    for (int i = 0; i < 10; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop);
      model_frame(b, stop);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        bus_read(1'b0, d); e = model_data();
        n_checks++;
        if (d !== e) $display("FAIL rand_data%0d: got %h expected %h", i, d, e);
        else n_pass++;
      end
    end
    bus_read(1'b1, d); e = model_stat();
    n_checks++;
    if (d !== e) $display("FAIL rand_stat: got %h expected %h", d, e);
    else n_pass++;
    for (int i = 0; i <= DEPTH; i++) begin
      bus_read(1'b0, d); e = model_data();
      n_checks++;
      if (d !== e) $display("FAIL rand_drain%0d: got %h expected %h", i, d, e);
      else n_pass++;
    end
  endtask

  initial begin
    bus.cs  = 1'b0;
    bus.rd  = 1'b0;
    bus.adr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_framing_error();
    test_back_to_back_overflow();
    test_glitch();
    test_reset_midframe();
    test_full_push_pop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
